word_stacker: RTL
=================

# word_stacker

Gathers consecutive 32-bit words from the HWPE input streamer into one 128-bit AES block, with the first word in the most-significant lane. It hands each block to the AES core over a valid/ready handshake. It sits between the streamer sink and the cipher datapath, and is the receive-side counterpart of the 128→32 unstacker that feeds the output streamer. A separate output register lets collection of the next block overlap with a stalled consumer.

## Interface
Parameters:
- WORD_W, 32, input word width; multiple of 8
- NB_WORDS, 4, words per block; ≥2; block width = WORD_W*NB_WORDS

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; synchronous, active-high
- clr_i  in  1  synchronous soft clear; same effect as rst_i
- enable_i  in  1  when low, all state frozen and no handshakes
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input word accepted when in_valid_i & in_ready_o
- in_word_i  in  WORD_W  input word
- out_valid_o  out  1  block available
- out_ready_i  in  1  consumer accepts block
- out_block_o  out  WORD_W*NB_WORDS  assembled block
- busy_o  out  1  partial block held or output block pending

## Operation
- State: cnt_r, acc_r, out_r, full_r.
  - cnt_r: $clog2(NB_WORDS) bits, lane index.
  - acc_r: (NB_WORDS-1)*WORD_W bits, partial block.
  - out_r: block-wide output register.
  - full_r: output register occupied.
- Reset and clear: rst_i beats clr_i, which beats enable_i. Either one sets cnt_r=0, acc_r=0, out_r=0, full_r=0.
- Reset values: in_ready_o=0 (enable_i low), out_valid_o=0, out_block_o=0, busy_o=0.
- Input accept (in_fire) when enable_i & in_valid_i & in_ready_o:
  - cnt_r < NB_WORDS-1: word k goes to lane k of acc_r, where lane 0 = MS bits. cnt_r increments.
  - cnt_r == NB_WORDS-1: out_r loads {acc_r, in_word_i}, full_r goes to 1, cnt_r wraps to 0. acc_r is not cleared.
- Input ready:
  - in_ready_o = enable_i & ((cnt_r != NB_WORDS-1) | ~full_r | out_ready_i).
  - The first NB_WORDS-1 words of the next block are always accepted.
  - Only the final word stalls on a pending output.
- Output:
  - out_valid_o = enable_i & full_r.
  - out_block_o = out_r at all times.
- Output accept (out_fire) when out_valid_o & out_ready_i: full_r clears unless a final word is accepted in the same cycle.
- Final word and output accept in the same cycle: out_r reloads and full_r stays 1, so there is no bubble.
- busy_o = (cnt_r != 0) | full_r.
- enable_i low mid-block: cnt_r and acc_r hold, and collection resumes on the next lane once enable_i returns.
- Stalled consumer: out_r never changes while out_valid_o=1 and out_ready_i=0.

## Timing
- Latency: the final word is accepted on cycle N; out_valid_o=1 and out_block_o updated on cycle N+1.
- Sustained throughput: one word per cycle, one block per NB_WORDS cycles, with out_ready_i held high.
- Combinational paths:
  - out_ready_i → in_ready_o, only when cnt_r==NB_WORDS-1.
  - enable_i → both ready/valid outputs.
- No other input-to-output paths.
- in_ready_o does not depend on in_valid_i; out_valid_o does not depend on out_ready_i.

## Configuration
- Macro WORD_STACKER_BSWAP_EN.
- Defined: every input word is byte-reversed before lane insertion, e.g. 0x00112233 is stored as 0x33221100. The little-endian memory layout then maps to AES byte order.
- Undefined: words are inserted unchanged.
- Handshake and timing are identical in both cases.

## Structure
- Shared package aes_stream_pkg:
  - AES_WORD_W=32, AES_NB_WORDS=4, AES_BLOCK_W=128.
  - Typedefs aes_word_t and aes_block_t.
  - These are shared with the unstacker and the core.
- Sub-module word_bswap: purely combinational byte reversal of one WORD_W word. It is instantiated only under WORD_STACKER_BSWAP_EN.
- Everything else stays in word_stacker.

## Test plan
- Basic assembly: reset, enable, stream 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F with out_ready_i=1. Required: out_valid_o for exactly one cycle, 4 cycles after the first accept, with out_block_o=0x000102030405060708090A0B0C0D0E0F.
- Back-pressure: out_ready_i=0, stream 8 words back-to-back.
  - Block 1 is held stable.
  - Words 5–7 are accepted; word 8 sees in_ready_o=0.
  - Raising out_ready_i accepts word 8 in the same cycle, and block 2 follows next cycle with no lost words.
- Full-rate: 12 words with out_ready_i=1 and in_valid_i=1 throughout. Required: 3 blocks on cycles 5, 9, 13, with in_ready_o never low.
- Clear and reset mid-block:
  - After 2 words, pulse clr_i. Required: busy_o=0 next cycle, and the next 4 words form a clean block.
  - Repeat with rst_i. Required: all outputs 0.
- Enable freeze: after 3 words drop enable_i for 5 cycles while in_valid_i=1. Required: no accept, out_valid_o=0; the 4th word after re-enable completes the original block.
- Byte swap (WORD_STACKER_BSWAP_EN defined): the basic-assembly stimulus gives out_block_o=0x03020100070605040B0A09080F0E0D0C.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Shared AES stream definitions: word/block widths and typedefs used by the
// word stacker, the block unstacker and the cipher core.
package aes_stream_pkg;
  localparam int AES_WORD_W   = 32;
  localparam int AES_NB_WORDS = 4;
  localparam int AES_BLOCK_W  = AES_WORD_W * AES_NB_WORDS;

  typedef logic [AES_WORD_W-1:0]  aes_word_t;
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
endpackage

// File: rtl/word_bswap.sv
// Purely combinational byte reversal of one word (byte 0 <-> byte N-1, ...).
// Only instantiated by word_stacker when WORD_STACKER_BSWAP_EN is defined.
module word_bswap import aes_stream_pkg::*; #(
  parameter int WORD_W = AES_WORD_W
) (
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] swapped
);
  localparam int NB_BYTES = WORD_W / 8;

  for (genvar b = 0; b < NB_BYTES; b++) begin : g_byte
    assign swapped[8*b +: 8] = word[WORD_W-8-8*b +: 8];
  end
endmodule

// File: rtl/word_stacker.sv
// word_stacker: gathers NB_WORDS input words into one block, first word in the
// most-significant lane, and offers it on a valid/ready output. A separate
// output register lets the next block collect while the consumer stalls; only
// the final word of a block waits for the output register to free up.
// Optional build macro WORD_STACKER_BSWAP_EN: byte-reverse each word before
// it is inserted into its lane.
module word_stacker import aes_stream_pkg::*; #(
  parameter int WORD_W   = AES_WORD_W,
  parameter int NB_WORDS = AES_NB_WORDS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       enable_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WORD_W-1:0]          in_word_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WORD_W*NB_WORDS-1:0] out_block_o,
  output logic                       busy_o
);
  localparam int BLOCK_W = WORD_W * NB_WORDS;
  localparam int ACC_W   = (NB_WORDS - 1) * WORD_W;
  localparam int CNT_W   = $clog2(NB_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB_WORDS - 1);

  logic [CNT_W-1:0]   cnt_r;
  logic [ACC_W-1:0]   acc_r;
  logic [BLOCK_W-1:0] out_r;
  logic               full_r;

  logic [WORD_W-1:0]  ins_word;
  logic               at_last;
  logic               in_fire;
  logic               out_fire;
  logic               last_fire;

`ifdef WORD_STACKER_BSWAP_EN
  word_bswap #(.WORD_W(WORD_W)) u_bswap (
    .word    (in_word_i),
    .swapped (ins_word)
  );
`else
  assign ins_word = in_word_i;
`endif

  // Only the final lane has to wait for the output register; out_ready_i lets
  // a same-cycle hand-off reload the register without a bubble.
  assign at_last     = (cnt_r == LAST);
  assign in_ready_o  = enable_i & (~at_last | ~full_r | out_ready_i);
  assign out_valid_o = enable_i & full_r;
  assign out_block_o = out_r;
  assign busy_o      = (cnt_r != '0) | full_r;

  assign in_fire   = in_valid_i & in_ready_o;
  assign out_fire  = out_valid_o & out_ready_i;
  assign last_fire = in_fire & at_last;

  // Lane collection, block hand-off and output occupancy; enable low freezes all.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_r  <= '0;
      acc_r  <= '0;
      out_r  <= '0;
      full_r <= 1'b0;
    end else if (enable_i) begin
      if (in_fire) begin
        if (at_last) begin
          // acc_r is left as is; every lane is overwritten by the next block.
          out_r <= {acc_r, ins_word};
          cnt_r <= '0;
        end else begin
          for (int k = 0; k < NB_WORDS - 1; k++) begin
            if (cnt_r == CNT_W'(k)) acc_r[ACC_W-1-k*WORD_W -: WORD_W] <= ins_word;
          end
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
      if (last_fire)     full_r <= 1'b1;
      else if (out_fire) full_r <= 1'b0;
    end
  end
endmodule
